ac_cmd_builder: RTL

Upstream stage of the air-conditioner IR transmitter. Debounces five front-panel buttons and holds the AC setting state: power, mode, fan and temperature. On every accepted change it assembles the 35-bit and 32-bit command frames and raises a level request to the IR transmitter. It holds both frames stable until the transmitter reports completion.

---
 rtl/ac_ir_pkg.sv | 68 ++++++
 rtl/ac_btn_debounce.sv | 42 ++++
 rtl/ac_cmd_builder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ac_ir_pkg.sv
// Shared encodings, frame field layout and frame builders for the AC IR command path.
package ac_ir_pkg;

    typedef enum logic [2:0] {
        MODE_AUTO = 3'd0,
        MODE_COOL = 3'd1,
        MODE_DRY  = 3'd2,
        MODE_FAN  = 3'd3,
        MODE_HEAT = 3'd4
    } ac_mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBuild = 2'd1,
        StSend  = 2'd2,
        StGap   = 2'd3
    } acb_state_e;

    localparam logic [1:0]  FAN_MAX      = 2'd3;
    localparam int unsigned TEMP_MIN_DEF = 16;
    localparam int unsigned TEMP_MAX_DEF = 30;
    localparam logic [4:0]  TEMP_BASE    = 5'd16;
    localparam logic [4:0]  TEMP_RST     = 5'd26;

    localparam logic [21:0] D35_FIXED = 22'h0A0040;
    localparam logic [2:0]  D35_TAIL  = 3'b010;
    localparam logic [27:0] D32_FIXED = 28'h0000200;

    localparam int unsigned D35_MODE_LSB  = 32;
    localparam int unsigned D35_POWER_BIT = 31;
    localparam int unsigned D35_FAN_LSB   = 29;
    localparam int unsigned D35_TEMP_LSB  = 25;
    localparam int unsigned D35_FIXED_LSB = 3;
    localparam int unsigned D32_CSUM_LSB  = 28;

    function automatic logic [3:0] temp_code(input logic [4:0] temp);
        logic [4:0] diff;
        diff = temp - TEMP_BASE;
        return diff[3:0];
    endfunction

    function automatic logic [3:0] calc_checksum(input logic [3:0] tcode, input logic [2:0] mode,
                                                 input logic [1:0] fan, input logic power);
        return tcode + {1'b0, mode} + {2'b00, fan} + {3'b000, power};
    endfunction

    function automatic logic [34:0] build_data35(input logic power, input logic [2:0] mode,
                                                 input logic [1:0] fan, input logic [3:0] tcode);
        logic [34:0] d;
        d = '0;
        d[D35_MODE_LSB +: 3]   = mode;
        d[D35_POWER_BIT]       = power;
        d[D35_FAN_LSB +: 2]    = fan;
        d[D35_TEMP_LSB +: 4]   = tcode;
        d[D35_FIXED_LSB +: 22] = D35_FIXED;
        d[2:0]                 = D35_TAIL;
        return d;
    endfunction

    function automatic logic [31:0] build_data32(input logic [3:0] csum);
        logic [31:0] d;
        d = '0;
        d[D32_CSUM_LSB +: 4] = csum;
        d[27:0]              = D32_FIXED;
        return d;
    endfunction

endpackage

// File: rtl/ac_btn_debounce.sv
// Two-flop synchronizer plus stable-level debouncer; emits a one-cycle pulse on an accepted press.
module ac_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // r_cnt counts consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_press <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/ac_cmd_builder.sv
// Button-driven AC setting state and IR command frame builder with request/done handshake.
// Optional SEND timeout with retry enabled by defining ACB_TIMEOUT_EN.
module ac_cmd_builder
    import ac_ir_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 2000000,
    parameter int unsigned GAP_CYC      = 5000000,
    parameter int unsigned TIMEOUT_CYC  = 50000000,
    parameter int unsigned TEMP_MIN     = TEMP_MIN_DEF,
    parameter int unsigned TEMP_MAX     = TEMP_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_power,
    input  logic        btn_mode,
    input  logic        btn_temp_up,
    input  logic        btn_temp_dn,
    input  logic        btn_fan,
    input  logic        tx_done,
    output logic [34:0] data35,
    output logic [31:0] data32,
    output logic        send_req,
    output logic        busy,
    output logic        tx_err
);

    localparam int unsigned BTN_FAN   = 0;
    localparam int unsigned BTN_DN    = 1;
    localparam int unsigned BTN_UP    = 2;
    localparam int unsigned BTN_MODE  = 3;
    localparam int unsigned BTN_POWER = 4;

    localparam int unsigned CNT_MAX = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [4:0] w_btn_raw;
    logic [4:0] w_press;

    assign w_btn_raw = {btn_power, btn_mode, btn_temp_up, btn_temp_dn, btn_fan};

    for (genvar g = 0; g < 5; g++) begin : g_db
        ac_btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (w_btn_raw[g]),
            .o_press(w_press[g])
        );
    end

    logic       r_power;
    logic [2:0] r_mode;
    logic [1:0] r_fan;
    logic [4:0] r_temp;

    logic       w_power_d;
    logic [2:0] w_mode_d;
    logic [1:0] w_fan_d;
    logic [4:0] w_temp_d;
    logic       w_change;

    always_comb begin
        w_power_d = r_power;
        w_mode_d  = r_mode;
        w_fan_d   = r_fan;
        w_temp_d  = r_temp;
        w_change  = 1'b0;
        if (w_press[BTN_POWER]) begin
            w_power_d = ~r_power;
            w_change  = 1'b1;
        end
        if (r_power) begin
            if (w_press[BTN_MODE]) begin
                w_mode_d = (r_mode == MODE_HEAT) ? MODE_AUTO : r_mode + 3'd1;
                w_change = 1'b1;
            end
            if (w_press[BTN_FAN]) begin
                w_fan_d  = (r_fan == FAN_MAX) ? 2'd0 : r_fan + 2'd1;
                w_change = 1'b1;
            end
            // Simultaneous up and down cancel out.
            if (w_press[BTN_UP] && !w_press[BTN_DN] && (r_temp < 5'(TEMP_MAX))) begin
                w_temp_d = r_temp + 5'd1;
                w_change = 1'b1;
            end
            if (w_press[BTN_DN] && !w_press[BTN_UP] && (r_temp > 5'(TEMP_MIN))) begin
                w_temp_d = r_temp - 5'd1;
                w_change = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_power <= 1'b0;
            r_mode  <= MODE_COOL;
            r_fan   <= 2'd0;
            r_temp  <= TEMP_RST;
        end else begin
            r_power <= w_power_d;
            r_mode  <= w_mode_d;
            r_fan   <= w_fan_d;
            r_temp  <= w_temp_d;
        end
    end

    acb_state_e       r_state;
    logic             r_pending;
    logic             r_send_req;
    logic [CNT_W-1:0] r_cnt;
    logic [34:0]      r_data35;
    logic [31:0]      r_data32;
    logic [3:0]       w_tcode;

    assign w_tcode = temp_code(r_temp);

`ifdef ACB_TIMEOUT_EN
    logic r_tx_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pending  <= 1'b0;
            r_send_req <= 1'b0;
            r_cnt      <= '0;
            r_data35   <= build_data35(1'b0, MODE_COOL, 2'd0, temp_code(TEMP_RST));
            r_data32   <= build_data32(calc_checksum(temp_code(TEMP_RST), MODE_COOL, 2'd0, 1'b0));
`ifdef ACB_TIMEOUT_EN
            r_tx_err   <= 1'b0;
`endif
        end else begin
`ifdef ACB_TIMEOUT_EN
            r_tx_err <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (r_pending) r_state <= StBuild;
                end
                StBuild: begin
                    r_data35   <= build_data35(r_power, r_mode, r_fan, w_tcode);
                    r_data32   <= build_data32(calc_checksum(w_tcode, r_mode, r_fan, r_power));
                    r_pending  <= 1'b0;
                    r_cnt      <= '0;
                    r_send_req <= 1'b1;
                    r_state    <= StSend;
                end
                StSend: begin
                    if (tx_done) begin
                        r_send_req <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= StGap;
                    end
`ifdef ACB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_send_req <= 1'b0;
                        r_tx_err   <= 1'b1;
                        r_pending  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= StGap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                StGap: begin
                    if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= r_pending ? StBuild : StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // A change landing in BUILD must survive the pending clear.
            if (w_change) r_pending <= 1'b1;
        end
    end

    assign data35   = r_data35;
    assign data32   = r_data32;
    assign send_req = r_send_req;
    assign busy     = (r_state != StIdle);
`ifdef ACB_TIMEOUT_EN
    assign tx_err   = r_tx_err;
`else
    assign tx_err   = 1'b0;
`endif

endmodule
